// File: rtl/ad9517_spi_slave_pkg.sv
// Shared types and constants for the AD9517 serial-port responder.
// Instruction field positions follow the 16-bit R/W, W1:W0, addr layout.
package ad9517_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        DATA,
        COMMIT,
        WAIT_CS
    } state_t;

    localparam int RW_BIT     = 15;
    localparam int W_MSB      = 14;
    localparam int W_LSB      = 13;
    localparam int ADDR_MSB   = 12;
    localparam int ADDR_W     = ADDR_MSB + 1;
    localparam int INSTR_BITS = 16;
    localparam int DATA_BITS  = 8;

    localparam logic [ADDR_W-1:0] IO_UPDATE_ADDR_DEF = 13'h232;

    function automatic logic addr_in_range(
        input logic [ADDR_W-1:0] a,
        input int                aw
    );
        return (32'(a) >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/ad9517_spi_slave_if.sv
// Four-wire serial control port plus the responder's output-enable.
// The master drives sclk/cs_n/mosi; the slave drives miso/oe.
interface ad9517_spi_slave_if;

    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic oe;

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        input  miso,
        input  oe
    );

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        output miso,
        output oe
    );

endinterface

// File: rtl/ad9517_spi_slave_in_sync.sv
// Brings SCLK/CS_n/MOSI into the clk domain and flags SCLK edges.
// Chains are data-only so a reset cannot fabricate a CS_n edge.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_n,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   w_sclk;

    always_ff @(posedge clk) begin
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        r_sclk_d    <= w_sclk;
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign o_sclk_rise = w_sclk & ~r_sclk_d;
    assign o_sclk_fall = ~w_sclk & r_sclk_d;
    assign o_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ad9517_spi_slave.sv
// AD9517 serial control port responder: 16-bit instruction, one data
// byte, local register file, oversampled in the clk domain.
module ad9517_spi_slave
    import ad9517_spi_pkg::*;
#(
    parameter int                REG_AW         = 8,
    parameter logic [ADDR_W-1:0] IO_UPDATE_ADDR = IO_UPDATE_ADDR_DEF,
    parameter int                SYNC_STAGES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ad9517_spi_slave_if.slave     spi,
    output logic                  o_reg_wr,
    output logic [ADDR_W-1:0]     o_reg_addr,
    output logic [DATA_BITS-1:0]  o_reg_data,
    output logic                  o_io_update,
    output logic                  o_busy,
    output logic                  o_frame_err
);

    localparam int DEPTH = 2 ** REG_AW;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_n;
    logic w_mosi;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .i_sclk      (spi.sclk),
        .i_cs_n      (spi.cs_n),
        .i_mosi      (spi.mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_n      (w_cs_n),
        .o_mosi      (w_mosi)
    );

    state_t                  r_state;
    logic                    r_armed;
    logic [4:0]              r_cnt;
    logic [INSTR_BITS-1:0]   r_instr;
    logic [DATA_BITS-1:0]    r_rx;
    logic [DATA_BITS-1:0]    r_tx;
    logic                    r_miso;
    logic                    r_oe;
    logic                    r_reg_wr;
    logic [ADDR_W-1:0]       r_reg_addr;
    logic [DATA_BITS-1:0]    r_reg_data;
    logic                    r_io_upd;
    logic                    r_frame_err;
    logic [DATA_BITS-1:0]    r_mem [DEPTH];

    logic [INSTR_BITS-1:0]   w_instr_nx;
    logic [ADDR_W-1:0]       w_rd_addr;
    logic [DATA_BITS-1:0]    w_rd_byte;
    logic [ADDR_W-1:0]       w_wr_addr;
    logic                    w_wr_in_range;
    logic                    w_io_hit;
    logic [DATA_BITS-1:0]    w_wr_byte;

    // Read address is taken from the instruction including the bit
    // arriving on this very edge.
    assign w_instr_nx = {r_instr[INSTR_BITS-2:0], w_mosi};
    assign w_rd_addr  = w_instr_nx[ADDR_MSB:0];
    assign w_rd_byte  = addr_in_range(w_rd_addr, REG_AW)
                      ? r_mem[w_rd_addr[REG_AW-1:0]]
                      : '0;

    assign w_wr_addr     = r_instr[ADDR_MSB:0];
    assign w_wr_in_range = addr_in_range(w_wr_addr, REG_AW);
    assign w_io_hit      = (w_wr_addr == IO_UPDATE_ADDR) && r_rx[0];
    assign w_wr_byte     = w_io_hit ? (r_rx & 8'hFE) : r_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_instr     <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_data  <= '0;
            r_io_upd    <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_reg_wr    <= 1'b0;
            r_io_upd    <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // A frame needs CS_n seen high first, so a reset
                    // taken mid-frame never resumes that frame.
                    if (w_cs_n) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= INSTR;
                    end
                end
                INSTR: begin
                    if (w_cs_n) begin
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end else if (w_sclk_rise) begin
                        r_instr <= w_instr_nx;
                        r_cnt   <= r_cnt + 5'd1;
                        if (r_cnt == 5'(INSTR_BITS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= DATA;
                            if (w_instr_nx[RW_BIT]) begin
                                r_tx   <= w_rd_byte;
                                r_miso <= w_rd_byte[DATA_BITS-1];
                                r_oe   <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_cs_n) begin
                        r_frame_err <= 1'b1;
                        r_oe        <= 1'b0;
                        r_miso      <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        if (w_sclk_fall) begin
                            r_tx   <= {r_tx[DATA_BITS-2:0], 1'b0};
                            r_miso <= r_tx[DATA_BITS-2];
                        end
                        if (w_sclk_rise) begin
                            r_rx  <= {r_rx[DATA_BITS-2:0], w_mosi};
                            r_cnt <= r_cnt + 5'd1;
                            if (r_cnt == 5'(DATA_BITS - 1)) begin
                                r_state <= COMMIT;
                            end
                        end
                    end
                end
                COMMIT: begin
                    r_oe    <= 1'b0;
                    r_miso  <= 1'b0;
                    r_state <= WAIT_CS;
                    if (!r_instr[RW_BIT]) begin
                        if (w_wr_in_range) begin
                            r_mem[w_wr_addr[REG_AW-1:0]] <= w_wr_byte;
                            r_reg_wr   <= 1'b1;
                            r_reg_addr <= w_wr_addr;
                            r_reg_data <= r_rx;
                        end
                        r_io_upd <= w_io_hit;
                    end
                end
                WAIT_CS: begin
                    if (w_cs_n) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi.miso    = r_miso;
    assign spi.oe      = r_oe;
    assign o_reg_wr    = r_reg_wr;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_data  = r_reg_data;
    assign o_io_update = r_io_upd;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ad9517_spi_slave.sv
// Bench for ad9517_spi_slave: bit-banged SPI master, randomized
// frames, register-file model indexed by address.
module tb_ad9517_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr;
    logic [12:0] reg_addr;
    logic [7:0]  reg_data;
    logic        io_update;
    logic        busy;
    logic        frame_err;

    ad9517_spi_slave_if spi_bus ();

    ad9517_spi_slave dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi_bus),
        .o_reg_wr    (reg_wr),
        .o_reg_addr  (reg_addr),
        .o_reg_data  (reg_data),
        .o_io_update (io_update),
        .o_busy      (busy),
        .o_frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cnt_wr = 0;
    int          cnt_io = 0;
    int          cnt_fe = 0;
    logic [12:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    logic [7:0]  m_mem [256];

    always @(negedge clk) begin
        if (reg_wr) begin
            cnt_wr    <= cnt_wr + 1;
            last_addr <= reg_addr;
            last_data <= reg_data;
        end
        if (io_update) cnt_io <= cnt_io + 1;
        if (frame_err) cnt_fe <= cnt_fe + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_frame(input bit rw, input logic [12:0] addr,
                             input logic [7:0] wd, input int nbits,
                             input int rst_at, output logic [7:0] rd,
                             output int oe_bad);
        logic [23:0] fr;
        logic [1:0]  wbits;
        bit          exp_oe;
        bit          rst_done;
        wbits    = 2'($urandom_range(0, 3));
        fr       = {rw, wbits, addr, wd};
        rd       = '0;
        oe_bad   = 0;
        rst_done = 0;
        spi_bus.cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.mosi = fr[23-i];
            repeat (8) @(negedge clk);
            if (i == 4) chk("busy_mid", busy, 1);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_oe", spi_bus.oe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_miso", spi_bus.miso, 0);
                @(negedge clk);
                rst = 1'b0;
                rst_done = 1;
            end
            spi_bus.sclk = 1'b1;
            repeat (8) @(negedge clk);
            exp_oe = rw && !rst_done && i >= 15 && i <= 22;
            if (spi_bus.oe !== exp_oe) oe_bad++;
            if (exp_oe) rd[22-i] = spi_bus.miso;
            spi_bus.sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi_bus.cs_n = 1'b1;
        repeat (12) @(negedge clk);
        if (spi_bus.oe !== 1'b0) oe_bad++;
    endtask

    task automatic run(input bit rw, input logic [12:0] addr,
                       input logic [7:0] wd, input int nbits,
                       input int rst_at);
        int         wr0, io0, fe0, oe_bad;
        logic [7:0] rd;
        bit         full, in_rng, exp_wr, exp_io, exp_fe;
        wr0 = cnt_wr;
        io0 = cnt_io;
        fe0 = cnt_fe;
        spi_frame(rw, addr, wd, nbits, rst_at, rd, oe_bad);
        full   = (nbits == 24) && (rst_at < 0);
        in_rng = addr < 13'd256;
        exp_wr = full && !rw && in_rng;
        exp_io = full && !rw && addr == 13'h232 && wd[0];
        exp_fe = (nbits < 24) && (rst_at < 0);
        if (full && rw) begin
            chk("rd_data", rd, in_rng ? m_mem[addr[7:0]] : 8'h00);
        end
        chk("wr_pulses", cnt_wr - wr0, exp_wr);
        chk("io_pulses", cnt_io - io0, exp_io);
        chk("frame_err", cnt_fe - fe0, exp_fe);
        chk("oe_window", oe_bad, 0);
        chk("busy_end", busy, 0);
        if (exp_wr) begin
            chk("wr_addr", last_addr, addr);
            chk("wr_data", last_data, wd);
            m_mem[addr[7:0]] = (addr == 13'h232 && wd[0]) ? (wd & 8'hFE) : wd;
        end
        if (rst_at >= 0) begin
            foreach (m_mem[k]) m_mem[k] = 8'h00;
        end
    endtask

    initial begin
        int          sel, nb;
        logic [12:0] a;
        foreach (m_mem[k]) m_mem[k] = 8'h00;
        rst          = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.cs_n = 1'b1;
        spi_bus.mosi = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_miso", spi_bus.miso, 0);
        chk("rst_oe", spi_bus.oe, 0);
        chk("rst_wr", reg_wr, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_data", reg_data, 0);
        chk("rst_io", io_update, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        run(0, 13'h010, 8'h7C, 24, -1);
        run(1, 13'h010, 8'h00, 24, -1);
        run(0, 13'h232, 8'h01, 24, -1);
        run(1, 13'h232, 8'h00, 24, -1);
        run(0, 13'h1F0, 8'hAA, 24, -1);
        run(1, 13'h1F0, 8'h00, 24, -1);
        run(0, 13'h020, 8'h5A, 10, -1);
        run(1, 13'h020, 8'h00, 24, -1);
        run(0, 13'h020, 8'h3C, 24, -1);
        run(1, 13'h020, 8'h00, 24, -1);
        run(0, 13'h0FF, 8'h81, 24, -1);
        run(0, 13'h030, 8'h99, 24, 20);
        run(1, 13'h010, 8'h00, 24, -1);
        run(0, 13'h030, 8'h42, 24, -1);
        run(1, 13'h030, 8'h00, 24, -1);
        run(1, 13'h0FF, 8'h00, 24, -1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 13'($urandom_range(0, 31));
            else if (sel < 8)  a = 13'($urandom_range(256, 8191));
            else if (sel == 8) a = 13'h232;
            else               a = 13'($urandom_range(0, 255));
            nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 23) : 24;
            run(1'($urandom_range(0, 1)), a, 8'($urandom), nb, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
